// File: rtl/intc_mmio_pkg.sv
// Shared definitions for the intc_mmio interrupt controller:
// register offsets, VECTOR layout and the default bus base address.
package intc_mmio_pkg;

  localparam logic [31:0] INTC_DEFAULT_BASE  = 32'hFFFF_FF00;
  localparam int          INTC_VEC_VALID_BIT = 31;

  typedef enum logic [2:0] {
    INTC_PEND   = 3'd0,
    INTC_MASK   = 3'd1,
    INTC_EDGE   = 3'd2,
    INTC_CTRL   = 3'd3,
    INTC_VECTOR = 3'd4
  } intc_reg_e;

  function automatic logic [31:0] intc_vector(input logic valid, input logic [4:0] id);
    logic [31:0] v;
    v = 32'd0;
    v[INTC_VEC_VALID_BIT] = valid;
    v[4:0] = valid ? id : 5'd0;
    return v;
  endfunction

endpackage

// File: rtl/intc_mmio_if.sv
// Zero-wait-state CPU data-bus slave port for intc_mmio.
interface intc_mmio_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, we, addr, wdata, input rdata, ready);
  modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/intc_mmio_prio_enc.sv
// Combinational lowest-index-first priority encoder (valid + 5-bit id),
// used to form the VECTOR register of intc_mmio.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_id
);

  // Scanning from the top down lets the lowest set index win.
  always_comb begin
    o_valid = 1'b0;
    o_id    = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/intc_mmio.sv
// Memory-mapped interrupt controller driving the CPU's single registered INT line.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer per source ahead of edge detection.
module intc_mmio
  import intc_mmio_pkg::*;
#(
  parameter int               NSRC      = 8,
  parameter logic [31:0]      BASE_ADDR = INTC_DEFAULT_BASE,
  parameter logic [NSRC-1:0]  RST_EDGE  = {NSRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  i_src_in,
  intc_mmio_if.slave       bus,
  output logic             o_irq
);

  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_s_d;
  logic            r_gie;
  logic            r_irq;

  logic [NSRC-1:0] w_s;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_pend_next;
  logic [NSRC-1:0] w_active;
  logic            w_hit;
  logic            w_wr;
  logic [2:0]      w_off;
  logic            w_vec_valid;
  logic [4:0]      w_vec_id;
  logic            w_unused;

  assign w_hit    = bus.sel && (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr     = w_hit && bus.we;
  assign w_off    = bus.addr[4:2];
  assign w_unused = ^{bus.addr[1:0], bus.wdata};

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_src_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_src_in;
`endif

  // A rise landing in the same cycle as its W1C wins; level-mode bits just track the source.
  assign w_rise      = w_s & ~r_s_d;
  assign w_w1c       = (w_wr && (w_off == INTC_PEND)) ? bus.wdata[NSRC-1:0] : '0;
  assign w_pend_next = (r_edge & ((r_pend & ~w_w1c) | w_rise)) | (~r_edge & w_s);
  assign w_active    = r_pend & r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= RST_EDGE;
      r_gie  <= 1'b0;
      r_s_d  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_s_d  <= w_s;
      r_pend <= w_pend_next;
      r_irq  <= r_gie && (|w_active);
      if (w_wr && (w_off == INTC_MASK)) r_mask <= bus.wdata[NSRC-1:0];
      if (w_wr && (w_off == INTC_EDGE)) r_edge <= bus.wdata[NSRC-1:0];
      if (w_wr && (w_off == INTC_CTRL)) r_gie  <= bus.wdata[0];
    end
  end

  intc_prio_enc #(.N(NSRC)) u_prio_enc (
    .i_req   (w_active),
    .o_valid (w_vec_valid),
    .o_id    (w_vec_id)
  );

  // Reads return pre-write state, which keeps rdata purely combinational.
  always_comb begin
    bus.rdata = 32'd0;
    if (w_hit) begin
      case (w_off)
        INTC_PEND:   bus.rdata = 32'(r_pend);
        INTC_MASK:   bus.rdata = 32'(r_mask);
        INTC_EDGE:   bus.rdata = 32'(r_edge);
        INTC_CTRL:   bus.rdata = {31'd0, r_gie};
        INTC_VECTOR: bus.rdata = intc_vector(w_vec_valid, w_vec_id);
        default:     bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.ready = 1'b1;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_intc_mmio.sv
// Self-checking bench for intc_mmio (NSRC=8), directed scenarios plus a randomized
// phase compared against a per-source behavioural model; works with or without INTC_SYNC_EN.
module tb_intc_mmio;
  import intc_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] mPend, mMask, mEdge, mSprev;
  logic       mGie, mIrq;
  logic [7:0] mPipe[$];

  intc_mmio_if bus ();

  intc_mmio #(.NSRC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_src_in (src),
    .bus      (bus),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    mPend = 8'h00; mMask = 8'h00; mEdge = 8'hFF; mGie = 1'b0; mIrq = 1'b0; mSprev = 8'h00;
    mPipe.delete();
    for (int i = 0; i < SYNC; i++) mPipe.push_back(8'h00);
  endtask

  // One clock of the controller's rules, applied per source.
  task automatic model_step(input logic sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
    logic [7:0] s, np;
    logic       wr;
    logic [2:0] off;
    wr  = sel && we && (addr[31:5] == BASE[31:5]);
    off = addr[4:2];
    s   = (mPipe.size() == 0) ? src : mPipe[mPipe.size()-1];
    for (int i = 0; i < 8; i++) begin
      if (mEdge[i]) begin
        if (s[i] && !mSprev[i])                 np[i] = 1'b1;
        else if (wr && off == 3'd0 && wd[i])    np[i] = 1'b0;
        else                                    np[i] = mPend[i];
      end else begin
        np[i] = s[i];
      end
    end
    mIrq = mGie && ((mPend & mMask) != 8'h00);
    if (wr && off == 3'd1) mMask = wd[7:0];
    if (wr && off == 3'd2) mEdge = wd[7:0];
    if (wr && off == 3'd3) mGie  = wd[0];
    mPend  = np;
    mSprev = s;
    if (mPipe.size() > 0) begin
      mPipe.push_front(src);
      void'(mPipe.pop_back());
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0: return {24'd0, mPend};
      3'd1: return {24'd0, mMask};
      3'd2: return {24'd0, mEdge};
      3'd3: return {31'd0, mGie};
      3'd4: begin
        for (int i = 0; i < 8; i++)
          if (mPend[i] && mMask[i]) return {1'b1, 26'd0, 5'(i)};
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic cycle_a(input logic sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    bus.sel = sel; bus.we = we; bus.addr = addr; bus.wdata = wd;
    model_step(sel, we, addr, wd);
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] off, input logic [31:0] wd);
    cycle_a(1'b1, 1'b1, BASE | {27'd0, off, 2'b00}, wd);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_a(1'b0, 1'b0, BASE, 32'd0);
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = BASE | {27'd0, off, 2'b00};
    #1;
    d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.ready); end
    bus.addr = BASE; #1;
    checks++; if (bus.rdata !== 32'd0) begin errors++; $display("[TB] FAIL rdata_unsel: got %h want 0", bus.rdata); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_pend: got %h want 0", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_mask: got %h want 0", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h want 0", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("[TB] FAIL reset_edge: got %h want ff", d); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    write_reg(3'd1, 32'h04);
    write_reg(3'd3, 32'h01);
    src = 8'h04;
    for (int k = 1; k <= LAT; k++) begin
      idle(1);
      if (k == 1) src = 8'h00;
      checks++;
      if (irq !== (k == LAT)) begin
        errors++; $display("[TB] FAIL edge_latency_%0d: got %b want %b", k, irq, (k == LAT));
      end
    end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h04) begin errors++; $display("[TB] FAIL edge_pend: got %h want 04", d); end
    bus_read(3'd4, d);
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("[TB] FAIL edge_vector: got %h want 80000002", d); end
    write_reg(3'd0, 32'h04);
    checks++; if (irq !== mIrq) begin errors++; $display("[TB] FAIL edge_w1c_edge: got %b want %b", irq, mIrq); end
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL edge_w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    write_reg(3'd1, 32'h00);
    src = 8'h00;
    idle(LAT);
    write_reg(3'd0, 32'hFF);
    src = 8'h62;
    idle(1);
    src = 8'h00;
    idle(LAT);
    bus_read(3'd0, d);
    checks++; if (d !== 32'h62 || d !== model_read(3'd0)) begin errors++; $display("[TB] FAIL prio_pend: got %h want 62", d); end
    write_reg(3'd1, 32'h60);
    bus_read(3'd4, d);
    checks++; if (d !== 32'h8000_0005) begin errors++; $display("[TB] FAIL prio_vector: got %h want 80000005", d); end
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL prio_irq: got %b want 1", irq); end
    write_reg(3'd1, 32'h00);
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL prio_masked_irq: got %b want 0", irq); end
    bus_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL prio_masked_vector: got %h want 0", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h62) begin errors++; $display("[TB] FAIL prio_masked_pend: got %h want 62", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    write_reg(3'd0, 32'hFF);
    write_reg(3'd1, 32'h08);
    src = 8'h08;
    idle(1);
    src = 8'h00;
    idle(LAT + 1);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL coll_setup_irq: got %b want 1", irq); end
    src = 8'h08;
    idle(SYNC);
    write_reg(3'd0, 32'h08);
    src = 8'h00;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL coll_irq_%0d: got %b want 1", k, irq); end
    end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h08) begin errors++; $display("[TB] FAIL coll_pend: got %h want 08", d); end
    idle(LAT);
    write_reg(3'd0, 32'h08);
    idle(1);
    bus_read(3'd0, d);
    checks++; if (d !== 32'h00) begin errors++; $display("[TB] FAIL coll_clear_pend: got %h want 00", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL coll_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    write_reg(3'd2, 32'h00);
    write_reg(3'd1, 32'h01);
    write_reg(3'd3, 32'h01);
    src = 8'h01;
    idle(LAT);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL level_irq: got %b want 1", irq); end
    write_reg(3'd0, 32'h01);
    bus_read(3'd0, d);
    checks++; if (d !== 32'h01) begin errors++; $display("[TB] FAIL level_w1c_pend: got %h want 01", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL level_w1c_irq: got %b want 1", irq); end
    src = 8'h00;
    for (int k = 1; k <= LAT; k++) begin
      idle(1);
      checks++;
      if (irq !== (k < LAT)) begin
        errors++; $display("[TB] FAIL level_drop_%0d: got %b want %b", k, irq, (k < LAT));
      end
    end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h00) begin errors++; $display("[TB] FAIL level_pend_low: got %h want 00", d); end
    write_reg(3'd2, 32'hFF);
  endtask

  task automatic test_random();
    logic [31:0] d, addr, wd;
    logic [2:0]  off;
    logic        sel, we;
    write_reg(3'd1, 32'hFF);
    write_reg(3'd2, {24'd0, 8'($urandom)});
    write_reg(3'd3, 32'h01);
    for (int n = 0; n < 300; n++) begin
      src  = 8'($urandom);
      sel  = ($urandom_range(0, 3) == 0);
      we   = sel;
      off  = 3'($urandom_range(0, 7));
      wd   = $urandom;
      addr = BASE | {27'd0, off, 2'b00};
      if ($urandom_range(0, 7) == 0) addr = addr ^ 32'h0000_0100;
      if (off == 3'd3 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      cycle_a(sel, we, addr, wd);
      checks++; if (irq !== mIrq) begin errors++; $display("[TB] FAIL rand_irq_%0d: got %b want %b", n, irq, mIrq); end
      off = 3'($urandom_range(0, 7));
      bus_read(off, d);
      checks++;
      if (d !== model_read(off)) begin
        errors++; $display("[TB] FAIL rand_read_%0d off%0d: got %h want %h", n, off, d, model_read(off));
      end
    end
    src = 8'h00;
    idle(LAT);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    write_reg(3'd2, 32'hFF);
    write_reg(3'd0, 32'hFF);
    write_reg(3'd1, 32'h01);
    write_reg(3'd3, 32'h01);
    src = 8'h01;
    idle(1);
    src = 8'h00;
    idle(LAT);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL arst_setup_irq: got %b want 1", irq); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL arst_irq: got %b want 0", irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL arst_pend: got %h want 0", d); end
    #1;
    rst = 1'b0;
    model_reset();
    idle(1);
    bus_read(3'd6, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL unmapped_18: got %h want 0", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL arst_mask: got %h want 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL arst_irq_after: got %b want 0", irq); end
  endtask

  initial begin
    rst = 1'b1; src = 8'h00;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    model_reset();
    $display("[TB] start, synchronizer stages = %0d", SYNC);
    test_reset();
    test_edge();
    test_priority();
    test_collision();
    test_level();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
